// File: rtl/vga_timing_counter.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_counter
// Brief    : Pixel prescaler, H/V position counters and per-frame strobes for
//            the VGA sync decoder. Optional checks: define VGA_TIMING_CHECK_EN.
// Revision : 1.0  initial release
// ============================================================================
module vga_timing_counter #(
  parameter int HMAX     = 800,
  parameter int VMAX     = 525,
  parameter int HDISPLAY = 640,
  parameter int VDISPLAY = 480,
  parameter int CLK_DIV  = 2,
  parameter int FRAME_W  = 16
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_n,
  input  logic                    i_En,
  output logic [$clog2(HMAX)-1:0] o_H_count,
  output logic [$clog2(VMAX)-1:0] o_V_count,
  output logic                    o_pix_tick,
  output logic                    o_line_end,
  output logic                    o_frame_start,
  output logic                    o_vblank_start,
  output logic [FRAME_W-1:0]      o_frame_count
);

  localparam int c_HW = $clog2(HMAX);
  localparam int c_VW = $clog2(VMAX);
  localparam int c_DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [c_HW-1:0] c_H_LAST   = c_HW'(HMAX - 1);
  localparam logic [c_VW-1:0] c_V_LAST   = c_VW'(VMAX - 1);
  localparam logic [c_VW-1:0] c_V_VBLANK = c_VW'(VDISPLAY);
  localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(CLK_DIV - 1);

  logic [c_DW-1:0]    r_div;
  logic [c_HW-1:0]    r_h;
  logic [c_VW-1:0]    r_v;
  logic [FRAME_W-1:0] r_frame;
  logic               r_frame_start;
  logic               r_vblank_start;

  logic               w_tick;
  logic               w_h_last;
  logic               w_v_last;
  logic [c_VW-1:0]    w_v_next;

  always_comb begin
    w_tick   = i_En && (r_div == c_DIV_LAST);
    w_h_last = (r_h == c_H_LAST);
    w_v_last = (r_v == c_V_LAST);
    w_v_next = w_v_last ? '0 : r_v + 1'b1;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_div          <= '0;
      r_h            <= '0;
      r_v            <= '0;
      r_frame        <= '0;
      r_frame_start  <= 1'b0;
      r_vblank_start <= 1'b0;
    end else begin
      // Strobes last one system clock, independent of the pixel divider
      r_frame_start  <= 1'b0;
      r_vblank_start <= 1'b0;

      if (!i_En || (r_div == c_DIV_LAST)) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + 1'b1;
      end

      if (w_tick) begin
        if (w_h_last) begin
          r_h <= '0;
          r_v <= w_v_next;
          if (w_v_last) begin
            r_frame       <= r_frame + 1'b1;
            r_frame_start <= 1'b1;
          end
          if (w_v_next == c_V_VBLANK) begin
            r_vblank_start <= 1'b1;
          end
        end else begin
          r_h <= r_h + 1'b1;
        end
      end
    end
  end

  assign o_H_count      = r_h;
  assign o_V_count      = r_v;
  assign o_pix_tick     = w_tick;
  assign o_line_end     = w_tick && w_h_last;
  assign o_frame_start  = r_frame_start;
  assign o_vblank_start = r_vblank_start;
  assign o_frame_count  = r_frame;

`ifdef VGA_TIMING_CHECK_EN
  if (HDISPLAY >= HMAX) begin : g_chk_hdisplay
    $error("vga_timing_counter: HDISPLAY must be less than HMAX");
  end
  if (VDISPLAY >= VMAX) begin : g_chk_vdisplay
    $error("vga_timing_counter: VDISPLAY must be less than VMAX");
  end
  if (CLK_DIV < 1) begin : g_chk_clk_div
    $error("vga_timing_counter: CLK_DIV must be at least 1");
  end

  a_h_range: assert property (@(posedge i_Clk) disable iff (!i_Rst_n)
    int'(r_h) < HMAX);
  a_v_range: assert property (@(posedge i_Clk) disable iff (!i_Rst_n)
    int'(r_v) < VMAX);
  a_strobe_excl: assert property (@(posedge i_Clk) disable iff (!i_Rst_n)
    !(r_frame_start && r_vblank_start));
  a_fs_single: assert property (@(posedge i_Clk) disable iff (!i_Rst_n)
    r_frame_start |=> !r_frame_start);
  a_vb_single: assert property (@(posedge i_Clk) disable iff (!i_Rst_n)
    r_vblank_start |=> !r_vblank_start);
`endif

endmodule
`default_nettype wire
